// File: rtl/host_packet_injector.sv
// Host-to-switch packet injector: Avalon-MM slave feeding three word FIFOs
// whose heads drive switch inputs 1..3 over valid/ready, with status readback.
module host_packet_injector #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] input1,
  output logic [31:0] input2,
  output logic [31:0] input3,
  output logic        in_valid1,
  output logic        in_valid2,
  output logic        in_valid3,
  input  logic        in_ready1,
  input  logic        in_ready2,
  input  logic        in_ready3
);

  localparam int AW = $clog2(DEPTH);
  localparam int NP = 3;
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [NP][DEPTH];
  logic [AW:0]   cnt_q [NP];
  logic [AW:0]   cnt_d [NP];
  logic [AW-1:0] rp_q  [NP];
  logic [AW-1:0] rp_d  [NP];
  logic [AW-1:0] wp_q  [NP];
  logic [AW-1:0] wp_d  [NP];
  logic [31:0]   dlv_q [NP];
  logic [31:0]   dlv_d [NP];
  logic [2:0]    ovf_q, ovf_d;
  logic          en_q, en_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [NP-1:0] vld, rdy, push, pop;
  logic [NP-1:0] wen, full, ovf_set;
  logic          wr_any, wr_ctrl, flush, wr_ovf;

  assign wr_any  = chipselect && write;
  assign wr_ctrl = wr_any && (address == 4'd0);
  assign flush   = wr_ctrl && writedata[1];
  assign wr_ovf  = wr_any && (address == 4'd11);

  assign rdy = {in_ready3, in_ready2, in_ready1};

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      vld[p] = en_q && (cnt_q[p] != '0);
    end
  end

  assign in_valid1 = vld[0];
  assign in_valid2 = vld[1];
  assign in_valid3 = vld[2];
  assign input1    = mem_q[0][rp_q[0]];
  assign input2    = mem_q[1][rp_q[1]];
  assign input3    = mem_q[2][rp_q[2]];
  assign readdata  = rdata_q;

  // Flush overrides any push/pop on the same edge; a full FIFO still
  // accepts a push when its head is popped on that edge.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      push[p]    = wr_any && (address == 4'(p + 1));
      pop[p]     = vld[p] && rdy[p];
      full[p]    = (cnt_q[p] == FULLC);
      wen[p]     = 1'b0;
      ovf_set[p] = 1'b0;
      cnt_d[p]   = cnt_q[p];
      rp_d[p]    = rp_q[p];
      wp_d[p]    = wp_q[p];
      dlv_d[p]   = dlv_q[p];
      if (flush) begin
        cnt_d[p] = '0;
        rp_d[p]  = '0;
        wp_d[p]  = '0;
      end else begin
        wen[p]     = push[p] && (!full[p] || pop[p]);
        ovf_set[p] = push[p] && full[p] && !pop[p];
        if (pop[p]) begin
          rp_d[p]  = rp_q[p] + 1'b1;
          dlv_d[p] = dlv_q[p] + 32'd1;
        end
        if (wen[p]) begin
          wp_d[p] = wp_q[p] + 1'b1;
        end
        cnt_d[p] = cnt_q[p] + {{AW{1'b0}}, wen[p]}
                 - {{AW{1'b0}}, pop[p]};
      end
    end
  end

  // Clear first, then set, so a concurrent overflow wins over W1C.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_ovf) begin
      ovf_d = ovf_d & ~writedata[2:0];
    end
    ovf_d = ovf_d | ovf_set;
    en_d  = wr_ctrl ? writedata[0] : en_q;
  end

  always_comb begin
    rdata_d = 32'd251;
    if (chipselect && read) begin
      unique case (address)
        4'd0:    rdata_d = {31'b0, en_q};
        4'd8:    rdata_d = 32'(cnt_q[0]);
        4'd9:    rdata_d = 32'(cnt_q[1]);
        4'd10:   rdata_d = 32'(cnt_q[2]);
        4'd11:   rdata_d = {29'b0, ovf_q};
        4'd12:   rdata_d = dlv_q[0];
        4'd13:   rdata_d = dlv_q[1];
        4'd14:   rdata_d = dlv_q[2];
        default: rdata_d = 32'd252;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        cnt_q[p] <= '0;
        rp_q[p]  <= '0;
        wp_q[p]  <= '0;
        dlv_q[p] <= '0;
      end
      ovf_q   <= '0;
      en_q    <= 1'b0;
      rdata_q <= 32'd251;
    end else begin
      for (int p = 0; p < NP; p++) begin
        cnt_q[p] <= cnt_d[p];
        rp_q[p]  <= rp_d[p];
        wp_q[p]  <= wp_d[p];
        dlv_q[p] <= dlv_d[p];
      end
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (wen[p] && !reset) begin
        mem_q[p][wp_q[p]] <= writedata;
      end
    end
  end

endmodule

// File: tb/tb_host_packet_injector.sv
// Bench for host_packet_injector: register table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_host_packet_injector;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] input1, input2, input3;
  logic        in_valid1, in_valid2, in_valid3;
  logic [2:0]  rdy = '0;

  always #5 clk = ~clk;

  host_packet_injector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect),
    .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata),
    .input1(input1), .input2(input2), .input3(input3),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_valid3(in_valid3), .in_ready1(rdy[0]),
    .in_ready2(rdy[1]), .in_ready3(rdy[2])
  );

  logic [2:0]  vld;
  logic [31:0] ins [3];
  assign vld = {in_valid3, in_valid2, in_valid1};
  assign ins[0] = input1;
  assign ins[1] = input2;
  assign ins[2] = input3;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain queues and counters.
  logic [31:0] mq [3][$];
  bit          m_en;
  bit   [2:0]  m_ovf;
  logic [31:0] m_dlv [3];
  logic [31:0] m_rd;

  typedef struct {
    bit          cs;
    bit          rd;
    bit          wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic cyc();
    bit fl;
    bit [2:0] pp;
    logic [31:0] nrd;
    int a;
    a = int'(address);
    fl = chipselect && write && a == 0 && writedata[1];
    for (int p = 0; p < 3; p++)
      pp[p] = m_en && mq[p].size() > 0 && rdy[p];
    nrd = 32'd251;
    if (chipselect && read) begin
      if (a == 0) nrd = {31'b0, m_en};
      else if (a >= 8 && a <= 10) nrd = mq[a-8].size();
      else if (a == 11) nrd = {29'b0, m_ovf};
      else if (a >= 12 && a <= 14) nrd = m_dlv[a-12];
      else nrd = 32'd252;
    end
    @(posedge clk);
    if (reset) begin
      for (int p = 0; p < 3; p++) begin
        mq[p].delete();
        m_dlv[p] = 0;
      end
      m_en = 0;
      m_ovf = 0;
      nrd = 32'd251;
    end else begin
      if (fl) begin
        for (int p = 0; p < 3; p++) mq[p].delete();
      end else begin
        for (int p = 0; p < 3; p++)
          if (pp[p]) begin
            void'(mq[p].pop_front());
            m_dlv[p] = m_dlv[p] + 1;
          end
      end
      if (chipselect && write && a == 11)
        m_ovf = m_ovf & ~writedata[2:0];
      if (!fl && chipselect && write && a >= 1 && a <= 3) begin
        if (mq[a-1].size() < DEPTH) mq[a-1].push_back(writedata);
        else m_ovf[a-1] = 1'b1;
      end
      if (chipselect && write && a == 0) m_en = writedata[0];
    end
    m_rd = nrd;
    #1;
    chk("readdata", readdata, m_rd);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("valid%0d", p + 1), {31'b0, vld[p]},
          {31'b0, m_en && mq[p].size() > 0});
      if (m_en && mq[p].size() > 0)
        chk($sformatf("input%0d", p + 1), ins[p], mq[p][0]);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write = 1'b1;
    read = 1'b0;
    address = a;
    writedata = d;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    chipselect = 1'b1;
    read = 1'b1;
    write = 1'b0;
    address = a;
    cyc();
    v = readdata;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rdy = '0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'd0,  32'd0,  32'd251};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'd0,  32'd0,  32'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'd5,  32'd0,  32'd252};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'd0,  32'd1,  32'd251};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  32'd0,  32'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'd1,  32'hA5, 32'd251};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'd8,  32'd0,  32'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'd15, 32'd0,  32'd252};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'd7,  32'd5,  32'd251};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd11, 32'd0,  32'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'd12, 32'd0,  32'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'd0,  32'd0,  32'd251};

    do_reset();
    chk("reset_rdata", readdata, 32'd251);
    chk("reset_valid", {29'b0, vld}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      chipselect = tbl[i].cs;
      read = tbl[i].rd;
      write = tbl[i].wr;
      address = tbl[i].a;
      writedata = tbl[i].d;
      cyc();
      chk($sformatf("tbl%0d", i), readdata, tbl[i].exp);
    end
    idle();

    // 1: single word delivered once
    do_reset();
    wr(4'd0, 32'd1);
    wr(4'd1, 32'hA5);
    chk("t1_valid", {31'b0, in_valid1}, 32'd1);
    chk("t1_input", input1, 32'hA5);
    rdy[0] = 1'b1;
    cyc();
    chk("t1_gone", {31'b0, in_valid1}, 32'd0);
    cyc();
    rdy[0] = 1'b0;
    rd(4'd12, v);
    chk("t1_dlv", v, 32'd1);

    // 2: overflow on port 2 then in-order drain
    do_reset();
    for (int i = 0; i < 17; i++) wr(4'd2, 32'(i));
    rd(4'd9, v);
    chk("t2_cnt", v, 32'd16);
    rd(4'd11, v);
    chk("t2_ovf", v, 32'd2);
    rdy[1] = 1'b1;
    wr(4'd0, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", input2, 32'(i));
      cyc();
    end
    chk("t2_empty", {31'b0, in_valid2}, 32'd0);
    rdy[1] = 1'b0;
    rd(4'd13, v);
    chk("t2_dlv", v, 32'd16);

    // 3: push into a full FIFO while popping
    do_reset();
    for (int i = 0; i < 16; i++) wr(4'd3, 32'(100 + i));
    wr(4'd0, 32'd1);
    rdy[2] = 1'b1;
    wr(4'd3, 32'h77);
    rdy[2] = 1'b0;
    rd(4'd10, v);
    chk("t3_cnt", v, 32'd16);
    rd(4'd11, v);
    chk("t3_ovf", v, 32'd0);
    rdy[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t3_last", input3, 32'h77);
      cyc();
    end
    rdy[2] = 1'b0;

    // 4: flush with a pop on the same edge
    do_reset();
    wr(4'd0, 32'd0);
    for (int p = 1; p <= 3; p++)
      for (int i = 0; i < 3; i++) wr(4'(p), 32'(p * 16 + i));
    wr(4'd0, 32'd1);
    rdy[0] = 1'b1;
    wr(4'd0, 32'd3);
    rdy[0] = 1'b0;
    chk("t4_valid", {29'b0, vld}, 32'd0);
    for (int p = 0; p < 3; p++) begin
      rd(4'(8 + p), v);
      chk("t4_cnt", v, 32'd0);
    end
    rd(4'd11, v);
    chk("t4_ovf", v, 32'd0);
    rd(4'd0, v);
    chk("t4_en", v, 32'd1);
    rd(4'd12, v);
    chk("t4_dlv", v, 32'd0);

    // 5: pause and resume delivery
    do_reset();
    for (int i = 0; i < 6; i++) wr(4'd1, 32'(200 + i));
    wr(4'd0, 32'd1);
    rdy[0] = 1'b1;
    cyc();
    cyc();
    wr(4'd0, 32'd0);
    chk("t5_stop", {31'b0, in_valid1}, 32'd0);
    rd(4'd8, v);
    chk("t5_cnt", v, 32'd3);
    cyc();
    rd(4'd8, v);
    chk("t5_hold", v, 32'd3);
    wr(4'd0, 32'd1);
    chk("t5_resume", input1, 32'd203);
    rdy[0] = 1'b0;

    // 6: unmapped read, idle, reset mid-stream
    rd(4'd5, v);
    chk("t6_unmap", v, 32'd252);
    cyc();
    chk("t6_idle", readdata, 32'd251);
    wr(4'd2, 32'd9);
    wr(4'd3, 32'd8);
    rdy = 3'b111;
    cyc();
    do_reset();
    for (int p = 0; p < 7; p++) begin
      rd(4'(8 + p), v);
      chk("t6_zero", v, 32'd0);
    end

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      read = $urandom_range(0, 1) == 1;
      write = $urandom_range(0, 1) == 1;
      address = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) address = 4'($urandom_range(1, 3));
      writedata = $urandom;
      if (address == 4'd0) begin
        writedata[1] = ($urandom_range(0, 19) == 0);
        writedata[0] = ($urandom_range(0, 3) != 0);
      end
      rdy = 3'($urandom_range(0, 7));
      cyc();
    end
    reset = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
